// File: rtl/sap1_datapath.sv
// SAP-1 datapath: OR-combined W-bus, PC/MAR/MDR/IR/A/B/OUT registers, add/sub ALU
// with registered carry/zero flags, and a sticky multi-driver conflict flag.
module sap1_datapath #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [14:0]      ctrl,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [3:0]       mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_re,
  output logic             mem_we,
  output logic [3:0]       opcode,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] out_data,
  output logic [3:0]       pc,
  output logic             carry,
  output logic             zero,
  output logic             bus_conflict
);

  logic c_p, e_p, l_p, l_ma, l_md, ce, l_r, l_i, e_i, l_a, e_a, s_u, e_u, l_b, l_o;

  logic [3:0]       pc_q, pc_d, mar_q, mar_d;
  logic [WIDTH-1:0] mdr_q, mdr_d, ir_q, ir_d, a_q, a_d, b_q, b_d, out_q, out_d;
  logic             carry_q, carry_d, zero_q, zero_d, conflict_q, conflict_d;
  logic [WIDTH:0]   alu_sum;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       n_drv;

  // Active-low controls are inverted here so all internal enables are active-high.
  always_comb begin
    c_p  = ctrl[14];
    e_p  = ctrl[13];
    l_p  = ctrl[12];
    l_ma = ~ctrl[11];
    l_md = ~ctrl[10];
    ce   = ~ctrl[9];
    l_r  = ~ctrl[8];
    l_i  = ~ctrl[7];
    e_i  = ~ctrl[6];
    l_a  = ~ctrl[5];
    e_a  = ctrl[4];
    s_u  = ctrl[3];
    e_u  = ctrl[2];
    l_b  = ~ctrl[1];
    l_o  = ~ctrl[0];
  end

  always_comb begin
    alu_b   = s_u ? ~b_q : b_q;
    alu_sum = {1'b0, a_q} + {1'b0, alu_b} + {{WIDTH{1'b0}}, s_u};
  end

  always_comb begin
    bus = '0;
    if (e_p) bus = bus | {{(WIDTH-4){1'b0}}, pc_q};
    if (ce)  bus = bus | mem_rdata;
    if (e_i) bus = bus | {{(WIDTH-4){1'b0}}, ir_q[3:0]};
    if (e_a) bus = bus | a_q;
    if (e_u) bus = bus | alu_sum[WIDTH-1:0];
    n_drv = {2'b00, e_p} + {2'b00, ce} + {2'b00, e_i} + {2'b00, e_a} + {2'b00, e_u};
  end

  always_comb begin
    pc_d       = pc_q;
    mar_d      = mar_q;
    mdr_d      = mdr_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    out_d      = out_q;
    carry_d    = carry_q;
    zero_d     = zero_q;
    conflict_d = conflict_q | (n_drv > 3'd1);
    // A jump load wins over the increment when both are requested.
    if (l_p)      pc_d = bus[3:0];
    else if (c_p) pc_d = pc_q + 4'd1;
    if (l_ma) mar_d = bus[3:0];
    if (l_md) mdr_d = bus;
    if (l_i)  ir_d  = bus;
    if (l_a)  a_d   = bus;
    if (l_b)  b_d   = bus;
    if (l_o)  out_d = bus;
    if (e_u && l_a) begin
      carry_d = alu_sum[WIDTH];
      zero_d  = (alu_sum[WIDTH-1:0] == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      mar_q      <= '0;
      mdr_q      <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      out_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      mar_q      <= mar_d;
      mdr_q      <= mdr_d;
      ir_q       <= ir_d;
      a_q        <= a_d;
      b_q        <= b_d;
      out_q      <= out_d;
      carry_q    <= carry_d;
      zero_q     <= zero_d;
      conflict_q <= conflict_d;
    end
  end

  always_comb begin
    mem_addr     = mar_q;
    mem_wdata    = mdr_q;
    mem_re       = ce;
    mem_we       = l_r;
    opcode       = ir_q[7:4];
    out_data     = out_q;
    pc           = pc_q;
    carry        = carry_q;
    zero         = zero_q;
    bus_conflict = conflict_q;
  end

endmodule

// File: tb/tb_sap1_datapath.sv
// Directed bench for sap1_datapath: reset, fetch, ALU add/sub, PC wrap/jump,
// store strobe and sticky bus conflict, with hand-computed expectations.
module tb_sap1_datapath;

  localparam logic [14:0] IDLE = 15'h0FE3;
  localparam logic [14:0] CP = 15'h4000, EP = 15'h2000, LP = 15'h1000, LMA = 15'h0800;
  localparam logic [14:0] LMD = 15'h0400, CE = 15'h0200, LR = 15'h0100, LI = 15'h0080;
  localparam logic [14:0] EI = 15'h0040, LA = 15'h0020, EA = 15'h0010, SU = 15'h0008;
  localparam logic [14:0] EU = 15'h0004, LB = 15'h0002, LO = 15'h0001;

  logic        clk, rst_n;
  logic [14:0] ctrl;
  logic [7:0]  mem_rdata, mem_wdata, bus, out_data;
  logic [3:0]  mem_addr, opcode, pc;
  logic        mem_re, mem_we, carry, zero, bus_conflict;

  int n_cmp = 0;
  int n_err = 0;

  sap1_datapath #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
    .opcode(opcode), .bus(bus), .out_data(out_data), .pc(pc),
    .carry(carry), .zero(zero), .bus_conflict(bus_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Asserted controls are XORed into the idle word, which flips both polarities correctly.
  task automatic drive(input logic [14:0] act, input logic [7:0] rd);
    @(negedge clk);
    ctrl = IDLE ^ act;
    mem_rdata = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [14:0] act, input logic [7:0] rd);
    drive(act, rd);
    tick();
  endtask

  task automatic peek_a(input string tag, input logic [7:0] exp);
    drive(EA, 8'h00);
    chk(tag, {8'h00, bus}, {8'h00, exp});
  endtask

  initial begin
    rst_n = 1'b0;
    ctrl = IDLE;
    mem_rdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pc", {12'h0, pc}, 16'h0);
    chk("rst_mar", {12'h0, mem_addr}, 16'h0);
    chk("rst_bus", {8'h0, bus}, 16'h0);
    chk("rst_opcode", {12'h0, opcode}, 16'h0);
    chk("rst_re_we", {14'h0, mem_re, mem_we}, 16'h0);
    chk("rst_out", {8'h0, out_data}, 16'h0);
    chk("rst_flags", {13'h0, carry, zero, bus_conflict}, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-run
    run(CE | LA, 8'h55);
    run(CE | LP, 8'h07);
    chk("pre_rst_pc", {12'h0, pc}, 16'h7);
    run(EA | LO, 8'h00);
    chk("pre_rst_out", {8'h0, out_data}, 16'h55);
    drive(EA, 8'h00);
    chk("pre_rst_a", {8'h0, bus}, 16'h55);
    drive(15'h0, 8'h00);
    rst_n = 1'b0;
    #1;
    chk("async_pc", {12'h0, pc}, 16'h0);
    chk("async_out", {8'h0, out_data}, 16'h0);
    rst_n = 1'b1;
    peek_a("async_a", 8'h00);

    // Fetch
    drive(EP | LMA, 8'h00);
    chk("fetch_bus_pc", {8'h0, bus}, 16'h00);
    tick();
    chk("fetch_mar0", {12'h0, mem_addr}, 16'h0);
    run(CP, 8'h00);
    chk("fetch_pc1", {12'h0, pc}, 16'h1);
    drive(CE | LI, 8'h2E);
    chk("fetch_bus_ram", {8'h0, bus}, 16'h2E);
    chk("fetch_re", {15'h0, mem_re}, 16'h1);
    tick();
    chk("fetch_opcode", {12'h0, opcode}, 16'h2);
    drive(EI, 8'h00);
    chk("fetch_bus_ir", {8'h0, bus}, 16'h0E);
    run(EP | LMA, 8'h00);
    chk("fetch_mar1", {12'h0, mem_addr}, 16'h1);

    // ADD
    run(CE | LA, 8'h05);
    run(CE | LB, 8'h03);
    drive(EU | LA, 8'h00);
    chk("add1_bus", {8'h0, bus}, 16'h08);
    tick();
    chk("add1_flags", {14'h0, carry, zero}, 16'h0);
    peek_a("add1_a", 8'h08);
    run(CE | LA, 8'hFF);
    run(CE | LB, 8'h01);
    run(EU | LA, 8'h00);
    chk("add2_flags", {14'h0, carry, zero}, 16'h3);
    peek_a("add2_a", 8'h00);
    run(EU, 8'h00);
    chk("flags_hold", {14'h0, carry, zero}, 16'h3);

    // SUB
    run(CE | LA, 8'h05);
    run(CE | LB, 8'h07);
    run(SU | EU | LA, 8'h00);
    chk("sub_flags", {14'h0, carry, zero}, 16'h0);
    peek_a("sub_a", 8'hFE);

    // PC boundaries
    run(CE | LP, 8'h0F);
    run(CP, 8'h00);
    chk("pc_wrap", {12'h0, pc}, 16'h0);
    run(CE | LI, 8'h79);
    run(CP | LP | EI, 8'h00);
    chk("pc_jump_prio", {12'h0, pc}, 16'h9);

    // Store
    chk("no_conflict", {15'h0, bus_conflict}, 16'h0);
    run(CE | LA, 8'h42);
    run(EA | LMD, 8'h00);
    chk("store_wdata", {8'h0, mem_wdata}, 16'h42);
    drive(LR, 8'h00);
    chk("store_we_on", {15'h0, mem_we}, 16'h1);
    tick();
    drive(15'h0, 8'h00);
    chk("store_we_off", {15'h0, mem_we}, 16'h0);

    // Bus conflict
    drive(EP | EA, 8'h00);
    chk("conflict_bus_or", {8'h0, bus}, 16'h4B);
    tick();
    chk("conflict_set", {15'h0, bus_conflict}, 16'h1);
    for (int i = 0; i < 10; i++) run(15'h0, 8'h00);
    chk("conflict_sticky", {15'h0, bus_conflict}, 16'h1);
    chk("idle_bus", {8'h0, bus}, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
